// File: rtl/d_flip_flop_sync_pkg.sv
// Shared defaults and parameter validation for the d_flip_flop_sync register pipeline.
package d_flip_flop_sync_pkg;

    localparam int DFF_DEFAULT_WIDTH  = 1;
    localparam int DFF_DEFAULT_STAGES = 1;

    // Both the width and the depth must be at least one.
    function automatic bit dff_params_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register with synchronous active-high reset and clock enable.
module d_ff_stage
    import d_flip_flop_sync_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset wins over enable; with en low the stage simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/d_flip_flop_sync.sv
// STAGES-deep, WIDTH-bit register pipeline with synchronous reset and a common enable.
// Optional macro D_FLIP_FLOP_SYNC_QN_EN adds q_n, held in its own complement register chain.
module d_flip_flop_sync
    import d_flip_flop_sync_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter int               STAGES      = DFF_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef D_FLIP_FLOP_SYNC_QN_EN
    ,
    output logic [WIDTH-1:0] q_n
`endif
);

    if (!dff_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("d_flip_flop_sync: WIDTH and STAGES must both be >= 1");
    end

    logic [WIDTH-1:0] w_stage_q [STAGES];

    // All stages share en, so a frozen pipeline never shifts partially.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] w_stage_d;

        if (i == 0) begin : g_first
            assign w_stage_d = d;
        end else begin : g_next
            assign w_stage_d = w_stage_q[i-1];
        end

        d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (w_stage_d),
            .q   (w_stage_q[i])
        );
    end

    assign q = w_stage_q[STAGES-1];

`ifdef D_FLIP_FLOP_SYNC_QN_EN
    logic [WIDTH-1:0] w_stage_qn [STAGES];

    // Complement is captured at the input so q_n comes straight from a flop.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage_n
        logic [WIDTH-1:0] w_stage_dn;

        if (i == 0) begin : g_first
            assign w_stage_dn = ~d;
        end else begin : g_next
            assign w_stage_dn = w_stage_qn[i-1];
        end

        d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (~RESET_VALUE)
        ) u_stage_n (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (w_stage_dn),
            .q   (w_stage_qn[i])
        );
    end

    assign q_n = w_stage_qn[STAGES-1];
`endif

endmodule

// File: tb/tb_d_flip_flop_sync.sv
// Directed bench for d_flip_flop_sync: a 1-bit single-stage instance and an 8-bit three-stage one.
module tb_d_flip_flop_sync;

    logic       clk;
    logic       rst_a, en_a;
    logic [0:0] d_a, q_a, qn_a;
    logic       rst_b, en_b;
    logic [7:0] d_b, q_b, qn_b;

    int n_checks;
    int n_fail;

    d_flip_flop_sync #(
        .WIDTH       (1),
        .STAGES      (1),
        .RESET_VALUE (1'b0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .en  (en_a),
        .d   (d_a),
        .q   (q_a)
`ifdef D_FLIP_FLOP_SYNC_QN_EN
        ,
        .q_n (qn_a)
`endif
    );

    d_flip_flop_sync #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (8'h3C)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .en  (en_b),
        .d   (d_b),
        .q   (q_b)
`ifdef D_FLIP_FLOP_SYNC_QN_EN
        ,
        .q_n (qn_b)
`endif
    );

`ifndef D_FLIP_FLOP_SYNC_QN_EN
    assign qn_a = '0;
    assign qn_b = '0;
`endif

    // Clock: rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // d=1 at t=9 and d=0 at t=28; q changes only at the edges at t=10 and t=30.
    task automatic test_basic();
        rst_a = 1'b0; en_a = 1'b1; d_a = 1'b0;
        #9  d_a = 1'b1;
        #2;
        n_checks++;
        if (q_a !== 1'b1) begin
            n_fail++; $display("FAIL basic_rise: q=%b expected 1 at t=%0t", q_a, $time);
        end
        #17 d_a = 1'b0;
        #1;
        n_checks++;
        if (q_a !== 1'b1) begin
            n_fail++; $display("FAIL basic_between_edges: q=%b expected 1 at t=%0t", q_a, $time);
        end
        #2;
        n_checks++;
        if (q_a !== 1'b0) begin
            n_fail++; $display("FAIL basic_fall: q=%b expected 0 at t=%0t", q_a, $time);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); rst_a = 1'b1; d_a = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (q_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_value: q=%b expected 0", q_a);
        end
`ifdef D_FLIP_FLOP_SYNC_QN_EN
        n_checks++;
        if (qn_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_qn: q_n=%b expected 1", qn_a);
        end
`endif
        @(negedge clk); rst_a = 1'b0; d_a = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (q_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: q=%b expected 1", q_a);
        end
        // Reset pulse entirely between edges must not touch q.
        #4 rst_a = 1'b1;
        #2;
        n_checks++;
        if (q_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_no_async: q=%b expected 1", q_a);
        end
        @(negedge clk); rst_a = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (q_a !== 1'b1) begin
            n_fail++; $display("FAIL reset_pulse_missed: q=%b expected 1", q_a);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); en_a = 1'b0; d_a = ~d_a;
            @(posedge clk); #1;
            n_checks++;
            if (q_a !== 1'b1) begin
                n_fail++; $display("FAIL enable_hold[%0d]: q=%b expected 1", i, q_a);
            end
`ifdef D_FLIP_FLOP_SYNC_QN_EN
            n_checks++;
            if (qn_a !== 1'b0) begin
                n_fail++; $display("FAIL enable_hold_qn[%0d]: q_n=%b expected 0", i, qn_a);
            end
`endif
        end
        @(negedge clk); en_a = 1'b1; d_a = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (q_a !== 1'b0) begin
            n_fail++; $display("FAIL enable_resume: q=%b expected 0", q_a);
        end
    endtask

    // Reset beats enable; then RESET_VALUE drains out for two edges before data arrives.
    task automatic test_rst_en_priority();
        logic [7:0] exp_vec [3];
        exp_vec = '{8'h3C, 8'h3C, 8'h00};
        @(negedge clk); rst_b = 1'b1; en_b = 1'b1; d_b = 8'hFF;
        @(posedge clk); #1;
        n_checks++;
        if (q_b !== 8'h3C) begin
            n_fail++; $display("FAIL prio_reset: q=%h expected 3c", q_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rst_b = 1'b0; d_b = 8'h00;
            @(posedge clk); #1;
            n_checks++;
            if (q_b !== exp_vec[i]) begin
                n_fail++; $display("FAIL prio_drain[%0d]: q=%h expected %h", i, q_b, exp_vec[i]);
            end
`ifdef D_FLIP_FLOP_SYNC_QN_EN
            n_checks++;
            if (qn_b !== ~exp_vec[i]) begin
                n_fail++; $display("FAIL prio_drain_qn[%0d]: q_n=%h expected %h", i, qn_b, ~exp_vec[i]);
            end
`endif
        end
    endtask

    // A single A5 beat must appear exactly three edges later, for one cycle only.
    task automatic test_pipeline();
        logic [7:0] d_vec   [4];
        logic [7:0] exp_vec [4];
        d_vec   = '{8'hA5, 8'h00, 8'h00, 8'h00};
        exp_vec = '{8'h00, 8'h00, 8'hA5, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); en_b = 1'b1; d_b = d_vec[i];
            @(posedge clk); #1;
            n_checks++;
            if (q_b !== exp_vec[i]) begin
                n_fail++; $display("FAIL pipeline[%0d]: q=%h expected %h", i, q_b, exp_vec[i]);
            end
        end
    endtask

    // Freeze mid-stream with d changing; the pipeline must resume without losing a beat.
    task automatic test_freeze();
        logic [7:0] d_vec   [8];
        logic       en_vec  [8];
        logic [7:0] exp_vec [8];
        d_vec   = '{8'h11, 8'h22, 8'h33, 8'hFF, 8'hEE, 8'h44, 8'h55, 8'h66};
        en_vec  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_vec = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); en_b = en_vec[i]; d_b = d_vec[i];
            @(posedge clk); #1;
            n_checks++;
            if (q_b !== exp_vec[i]) begin
                n_fail++; $display("FAIL freeze[%0d]: q=%h expected %h", i, q_b, exp_vec[i]);
            end
`ifdef D_FLIP_FLOP_SYNC_QN_EN
            n_checks++;
            if (qn_b !== ~exp_vec[i]) begin
                n_fail++; $display("FAIL freeze_qn[%0d]: q_n=%h expected %h", i, qn_b, ~exp_vec[i]);
            end
`endif
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_b = 1'b0; en_b = 1'b0; d_b = 8'h00;
        test_basic();
        test_reset();
        test_enable();
        test_rst_en_priority();
        test_pipeline();
        test_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
